// File: rtl/repadd_sched.sv
// Round-robin scheduler sharing one repeated-addition multiplier datapath.
// Optional: define REPADD_ZERO_SKIP_EN to finish at once on a zero multiplicand.
module repadd_sched #(
   parameter int NREQ = 4,
   parameter int W    = 16,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] a_in,
   input  logic [NREQ*W-1:0] b_in,
   output logic [NREQ-1:0]   gnt,
   output logic              busy,
   output logic              done,
   output logic [IDW-1:0]    done_id,
   output logic [W-1:0]      din,
   output logic              ldA,
   output logic              ldB,
   output logic              ldP,
   output logic              clrP,
   output logic              decB,
   input  logic              eqz
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LDA  = 3'd1;
   localparam logic [2:0] S_LDB  = 3'd2;
   localparam logic [2:0] S_CHK  = 3'd3;
   localparam logic [2:0] S_ADD  = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   logic [2:0]      state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [IDW-1:0]  sel_q, sel_d;
   logic [IDW-1:0]  ptr_q, ptr_d;

   logic [NREQ-1:0] above;
   logic [NREQ-1:0] masked;
   logic [IDW-1:0]  win;
   logic            found;
   logic [W-1:0]    a_sel;
   logic [W-1:0]    b_sel;

   // Requesters above the pointer win first; otherwise wrap to the lowest index.
   always_comb begin
      above = '0;
      for (int j = 0; j < NREQ; j++) begin
         above[j] = (j > int'(ptr_q));
      end
      masked = req & above;
      found  = |req;
      win    = '0;
      for (int j = NREQ - 1; j >= 0; j--) begin
         if (req[j]) win = IDW'(j);
      end
      if (|masked) begin
         for (int j = NREQ - 1; j >= 0; j--) begin
            if (masked[j]) win = IDW'(j);
         end
      end
   end

   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (sel_q == IDW'(j)) begin
            a_sel = a_in[j*W +: W];
            b_sel = b_in[j*W +: W];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         S_IDLE: begin
            if (found) begin
               gnt_d = '0;
               for (int j = 0; j < NREQ; j++) begin
                  if (win == IDW'(j)) gnt_d[j] = 1'b1;
               end
               sel_d   = win;
               ptr_d   = win;
               state_d = S_LDA;
            end
         end
         S_LDA: state_d = S_LDB;
         S_LDB: begin
`ifdef REPADD_ZERO_SKIP_EN
            state_d = (a_sel == '0) ? S_DONE : S_CHK;
`else
            state_d = S_CHK;
`endif
         end
         S_CHK: state_d = eqz ? S_DONE : S_ADD;
         S_ADD: state_d = S_CHK;
         S_DONE: begin
            gnt_d   = '0;
            state_d = S_IDLE;
         end
         default: begin
            gnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         ptr_q   <= IDW'(NREQ - 1);
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
      end
   end

   // Outputs decode straight from state so reset clears them immediately.
   always_comb begin
      din     = '0;
      ldA     = 1'b0;
      ldB     = 1'b0;
      ldP     = 1'b0;
      clrP    = 1'b0;
      decB    = 1'b0;
      done    = 1'b0;
      done_id = '0;
      unique case (state_q)
         S_LDA: begin
            din = a_sel;
            ldA = 1'b1;
         end
         S_LDB: begin
            din  = b_sel;
            ldB  = 1'b1;
            clrP = 1'b1;
         end
         S_ADD: begin
            ldP  = 1'b1;
            decB = 1'b1;
         end
         S_DONE: begin
            done    = 1'b1;
            done_id = sel_q;
         end
         default: ;
      endcase
   end

   assign gnt  = gnt_q;
   assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_repadd_sched.sv
// Directed plus randomized bench for repadd_sched with a simple datapath model.
module tb_repadd_sched;
   localparam int NREQ = 4;
   localparam int W    = 16;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NREQ-1:0]   req = '0;
   logic [NREQ*W-1:0] a_in;
   logic [NREQ*W-1:0] b_in;
   logic [NREQ-1:0]   gnt;
   logic              busy, done;
   logic [IDW-1:0]    done_id;
   logic [W-1:0]      din;
   logic              ldA, ldB, ldP, clrP, decB;
   logic              eqz;

   logic [W-1:0] a_op [NREQ];
   logic [W-1:0] b_op [NREQ];

   logic [W-1:0]   ra = '0;
   logic [W-1:0]   rb = '0;
   logic [2*W-1:0] rp = '0;

   int n_cmp = 0;
   int n_bad = 0;
   int mptr;

   repadd_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
      .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
      .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .din(din),
      .ldA(ldA), .ldB(ldB), .ldP(ldP), .clrP(clrP), .decB(decB),
      .eqz(eqz)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         a_in[i*W +: W] = a_op[i];
         b_in[i*W +: W] = b_op[i];
      end
   end

   // Datapath: P += A and B -= 1 per ADD; not touched by scheduler reset.
   always @(posedge clk) begin
      if (ldA) ra <= din;
      if (ldB) rb <= din;
      else if (decB) rb <= rb - 1'b1;
      if (clrP) rp <= '0;
      else if (ldP) rp <= rp + {{W{1'b0}}, ra};
   end
   assign eqz = (rb == '0);

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
      for (int k = 1; k <= NREQ; k++) begin
         if (m[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic bit skips(input logic [W-1:0] a);
`ifdef REPADD_ZERO_SKIP_EN
      return (a == '0);
`else
      return 1'b0;
`endif
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      @(negedge clk);
      @(negedge clk);
      rst  = 1'b0;
      mptr = NREQ - 1;
   endtask

   // Waits for the expected grant, follows the op to done, checks everything.
   task automatic wait_op(input int id, input bit drop);
      int cyc, nldp, bad, elat, eldp;
      logic [W-1:0] a, b, da, db;
      logic [NREQ-1:0] g;
      bit seen;
      a = a_op[id];
      b = b_op[id];
      elat = skips(a) ? 3 : 2 * int'(b) + 4;
      eldp = skips(a) ? 0 : int'(b);
      cyc = 0;
      while (gnt == '0 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      g = '0;
      g[id] = 1'b1;
      chk("grant", 64'(gnt), 64'(g));
      cyc = 0; nldp = 0; bad = 0; seen = 0;
      da = '1; db = '1;
      while (!seen && cyc < 1000) begin
         cyc++;
         if (gnt !== g || busy !== 1'b1) bad++;
         if (ldA) da = din;
         if (ldB) db = din;
         if (!ldA && !ldB && din !== '0) bad++;
         if (ldP) nldp++;
         if (done) begin
            seen = 1;
            chk("done_id", 64'(done_id), 64'(id));
            chk("product", 64'(rp), 64'(a) * 64'(b));
            if (drop) req[id] = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
      chk("latency", 64'(cyc), 64'(elat));
      chk("ldP_count", 64'(nldp), 64'(eldp));
      chk("hold_bad", 64'(bad), 64'd0);
      chk("din_a", 64'(da), 64'(a));
      chk("din_b", 64'(db), 64'(b));
      @(negedge clk);
      chk("idle_gnt", 64'(gnt), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      int id, n;
      logic [NREQ-1:0] pend;
      for (int i = 0; i < NREQ; i++) begin
         a_op[i] = '0;
         b_op[i] = '0;
      end
      mptr = NREQ - 1;
      @(negedge clk);
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_id", 64'(done_id), 64'd0);
      chk("rst_din", 64'(din), 64'd0);
      chk("rst_strb", 64'({ldA, ldB, ldP, clrP, decB}), 64'd0);
      do_reset();

      // single op 9x7
      a_op[0] = 16'd9; b_op[0] = 16'd7;
      req = 4'b0001;
      wait_op(0, 1);

      // two simultaneous requests after reset
      do_reset();
      a_op[0] = 16'd3; b_op[0] = 16'd2;
      a_op[1] = 16'd5; b_op[1] = 16'd4;
      req = 4'b0011;
      for (int k = 0; k < 2; k++) begin
         id = rr_pick(req, mptr);
         mptr = id;
         wait_op(id, 1);
      end

      // all four held, B=1: order 0,1,2,3,0
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         a_op[i] = W'($urandom_range(1, 500));
         b_op[i] = 16'd1;
      end
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         id = rr_pick(req, mptr);
         chk("rr_order", 64'(id), 64'(k % NREQ));
         mptr = id;
         wait_op(id, 0);
      end
      req = '0;

      // B = 0
      a_op[1] = 16'd12; b_op[1] = 16'd0;
      req = 4'b0010;
      id = rr_pick(req, mptr);
      mptr = id;
      wait_op(id, 1);

      // randomized rounds
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < NREQ; i++) begin
            a_op[i] = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            b_op[i] = W'($urandom_range(0, 6));
         end
         pend = NREQ'($urandom_range(1, 15));
         req = pend;
         n = 0;
         while (req != '0 && n < 8) begin
            id = rr_pick(req, mptr);
            mptr = id;
            wait_op(id, 1);
            n++;
         end
      end

      // reset during the third ADD
      do_reset();
      a_op[0] = 16'd9; b_op[0] = 16'd7;
      req = 4'b0001;
      n = 0;
      for (int c = 0; c < 40 && n < 3; c++) begin
         @(negedge clk);
         if (ldP) n++;
      end
      chk("third_add", 64'(n), 64'd3);
      req = '0;
      rst = 1'b1;
      #1;
      chk("abort_gnt", 64'(gnt), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_strb", 64'({ldA, ldB, ldP, clrP, decB, done}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      mptr = NREQ - 1;
      n = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (done) n++;
      end
      chk("no_done", 64'(n), 64'd0);
      a_op[2] = 16'd6; b_op[2] = 16'd5;
      req = 4'b0100;
      id = rr_pick(req, mptr);
      mptr = id;
      wait_op(id, 1);

      // zero multiplicand, large B
      a_op[3] = 16'd0; b_op[3] = 16'd200;
      req = 4'b1000;
      id = rr_pick(req, mptr);
      mptr = id;
      wait_op(id, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
